// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for the multicycle MIPS-subset datapath. A single shared ALU and
//   a single unified memory are reused across fetch, decode, address
//   calculation, execute and write-back. This block drives every datapath mux
//   select, write enable and ALU op from the current state, the opcode, the ALU
//   zero flag and the memory-ready handshake.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset
//   op          instruction[31:26] from the instruction register
//   zero        ALU zero flag
//   mem_ready   memory completes the current access this cycle
//   pc_en       PC load enable (branch condition already folded in)
//   iord        memory address select: 0 = PC, 1 = ALU result register
//   mem_read    memory read request
//   mem_write   memory write request
//   ir_write    instruction register load
//   reg_dst     write address select: 0 = rt, 1 = rd
//   mem_to_reg  write data select: 0 = ALU result reg, 1 = memory data reg
//   reg_write   register bank write enable
//   alu_src_a   ALU A select: 0 = PC, 1 = register A
//   alu_src_b   ALU B select: 00 = B, 01 = 4, 10 = imm, 11 = imm << 2
//   alu_op      000 = add, 001 = sub, 010 = decode funct
//   pc_source   00 = ALU output, 01 = ALU result reg, 10 = jump target
//   halted      sticky illegal-opcode flag
//   state       current state, for debug
//
// Optional build macro: MULTICYCLE_CTRL_PERF_EN
//   Adds cycle_cnt[31:0] (clocks spent outside HALT) and instr_cnt[31:0]
//   (retired instructions). Both clear on rst and wrap modulo 2^32.
//
// State table
//   state     | meaning
//   FETCH     | read instruction at PC, PC <= PC + 4 when memory is ready
//   DECODE    | read registers, precompute branch target
//   MEM_ADDR  | effective address = A + sign-extended immediate
//   MEM_RD    | load data read, waits for mem_ready
//   MEM_WB    | load data written to rt
//   MEM_WR    | store data written, waits for mem_ready
//   R_EXEC    | R-type ALU operation on A and B
//   R_WB      | R-type result written to rd
//   BRANCH    | compare A and B, load branch target if equal
//   JUMP      | load jump target
//   I_EXEC    | addi ALU operation on A and immediate
//   I_WB      | addi result written to rt
//   HALT      | illegal opcode seen, core stopped until rst
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] OP_BEQ   = 6'h04,
  parameter logic [5:0] OP_J     = 6'h02,
  parameter logic [5:0] OP_ADDI  = 6'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        halted,
  output logic [3:0]  state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_HALT     = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  // Raw enables before the reset gate.
  logic w_pc_en;
  logic w_mem_read;
  logic w_mem_write;
  logic w_ir_write;
  logic w_reg_write;

  // Next-state logic. Encodings 13-15 fall into the default and park in HALT.
  always_comb begin
    w_next = S_HALT;
    case (r_state)
      S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (op == OP_LW || op == OP_SW) w_next = S_MEM_ADDR;
        else if (op == OP_RTYPE)        w_next = S_R_EXEC;
        else if (op == OP_BEQ)          w_next = S_BRANCH;
        else if (op == OP_J)            w_next = S_JUMP;
        else if (op == OP_ADDI)         w_next = S_I_EXEC;
        else                            w_next = S_HALT;
      end
      // Only lw/sw reach MEM_ADDR; anything but sw is treated as a load.
      S_MEM_ADDR: w_next = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   w_next = S_R_WB;
      S_R_WB:     w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_I_EXEC:   w_next = S_I_WB;
      S_I_WB:     w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  // Output decode. Everything not driven by a state stays 0.
  always_comb begin
    w_pc_en     = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    iord        = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_op      = 3'b000;
    pc_source   = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read = 1'b1;
        alu_src_b  = 2'b01;
        w_ir_write = mem_ready;
        w_pc_en    = mem_ready;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_read = 1'b1;
        iord       = 1'b1;
      end
      S_MEM_WB: begin
        w_reg_write = 1'b1;
        mem_to_reg  = 1'b1;
      end
      S_MEM_WR: begin
        w_mem_write = 1'b1;
        iord        = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b010;
      end
      S_R_WB: begin
        w_reg_write = 1'b1;
        reg_dst     = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        pc_source = 2'b01;
        w_pc_en   = zero;
      end
      S_JUMP: begin
        pc_source = 2'b10;
        w_pc_en   = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_I_WB: begin
        w_reg_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are gated by rst directly so an in-flight access is cut off the
  // moment reset rises, not at the next clock edge.
  assign pc_en     = w_pc_en     & ~rst;
  assign mem_read  = w_mem_read  & ~rst;
  assign mem_write = w_mem_write & ~rst;
  assign ir_write  = w_ir_write  & ~rst;
  assign reg_write = w_reg_write & ~rst;

  // HALT is absorbing until rst, so the flag is sticky by construction.
  assign halted = (r_state == S_HALT);
  assign state  = r_state;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;
  logic        w_retire;

  assign w_retire = (w_next == S_FETCH) &&
                    (r_state == S_MEM_WB || r_state == S_MEM_WR ||
                     r_state == S_R_WB   || r_state == S_BRANCH ||
                     r_state == S_JUMP   || r_state == S_I_WB);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (w_retire)          r_instr_cnt <= r_instr_cnt + 32'd1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed-vector bench for multicycle_ctrl. Each vector applies op, zero and
//   mem_ready for one clock and states the expected state, the five enables
//   {pc_en, mem_read, mem_write, ir_write, reg_write} and the mux/ALU fields
//   {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source}.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        pc_en, iord, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [2:0]  alu_op;
  logic [1:0]  pc_source;
  logic        halted;
  logic [3:0]  state;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int n_ir  = 0;
  int n_pc  = 0;

  localparam logic [3:0] ST_F   = 4'd0,  ST_D   = 4'd1,  ST_MA = 4'd2,
                         ST_MR  = 4'd3,  ST_MWB = 4'd4,  ST_MW = 4'd5,
                         ST_RX  = 4'd6,  ST_RWB = 4'd7,  ST_BR = 4'd8,
                         ST_J   = 4'd9,  ST_IX  = 4'd10, ST_IWB = 4'd11,
                         ST_H   = 4'd12;

  // {pc_en, mem_read, mem_write, ir_write, reg_write}
  localparam logic [4:0] E_NONE  = 5'b00000,
                         E_FRDY  = 5'b11010,
                         E_FWAIT = 5'b01000,
                         E_RD    = 5'b01000,
                         E_WR    = 5'b00100,
                         E_WB    = 5'b00001,
                         E_PC    = 5'b10000;

  // {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[2:0], pc_source[1:0]}
  localparam logic [10:0] M_F   = 11'b0000_01_000_00,
                          M_D   = 11'b0000_11_000_00,
                          M_MA  = 11'b0001_10_000_00,
                          M_MR  = 11'b1000_00_000_00,
                          M_MWB = 11'b0010_00_000_00,
                          M_MW  = 11'b1000_00_000_00,
                          M_RX  = 11'b0001_00_010_00,
                          M_RWB = 11'b0100_00_000_00,
                          M_BR  = 11'b0001_00_001_01,
                          M_J   = 11'b0000_00_000_10,
                          M_IX  = 11'b0001_10_000_00,
                          M_IWB = 11'b0000_00_000_00,
                          M_H   = 11'b0000_00_000_00;

  multicycle_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .iord       (iord),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_source  (pc_source),
    .halted     (halted),
    .state      (state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] en_vec();
    return {pc_en, mem_read, mem_write, ir_write, reg_write};
  endfunction

  function automatic logic [10:0] mux_vec();
    return {iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
  endfunction

  // Called 1 time unit after a rising edge: apply inputs, settle, check,
  // then advance to 1 time unit after the next rising edge.
  task automatic run_vec(input string tag, input logic [5:0] v_op, input logic v_zero,
                         input logic v_mr, input logic [3:0] v_st,
                         input logic [4:0] v_en, input logic [10:0] v_mux);
    op        = v_op;
    zero      = v_zero;
    mem_ready = v_mr;
    #1;
    chk({tag, ".state"},  32'(state),     32'(v_st));
    chk({tag, ".en"},     32'(en_vec()),  32'(v_en));
    chk({tag, ".mux"},    32'(mux_vec()), 32'(v_mux));
    chk({tag, ".halted"}, 32'(halted),    32'(v_st == ST_H));
    if (ir_write) n_ir++;
    if (pc_en)    n_pc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; op = 6'h00; zero = 1'b0; mem_ready = 1'b1;
    #2;
    chk("rst.state",  32'(state),    32'd0);
    chk("rst.halted", 32'(halted),   32'd0);
    chk("rst.en",     32'(en_vec()), 32'(E_NONE));
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // R-type: 0,1,6,7
    run_vec("r.f",  6'h00, 0, 1, ST_F,   E_FRDY, M_F);
    run_vec("r.d",  6'h00, 0, 1, ST_D,   E_NONE, M_D);
    run_vec("r.ex", 6'h00, 0, 1, ST_RX,  E_NONE, M_RX);
    run_vec("r.wb", 6'h00, 0, 1, ST_RWB, E_WB,   M_RWB);
`ifdef MULTICYCLE_CTRL_PERF_EN
    #1;
    chk("perf.instr1", instr_cnt, 32'd1);
    chk("perf.cycle4", cycle_cnt, 32'd4);
`endif

    // lw with two wait cycles in FETCH and in MEM_RD: 9 cycles
    n_ir = 0; n_pc = 0;
    run_vec("lw.f0", 6'h23, 0, 0, ST_F,   E_FWAIT, M_F);
    run_vec("lw.f1", 6'h23, 0, 0, ST_F,   E_FWAIT, M_F);
    run_vec("lw.f2", 6'h23, 0, 1, ST_F,   E_FRDY,  M_F);
    run_vec("lw.d",  6'h23, 0, 1, ST_D,   E_NONE,  M_D);
    run_vec("lw.ma", 6'h23, 0, 1, ST_MA,  E_NONE,  M_MA);
    run_vec("lw.r0", 6'h23, 0, 0, ST_MR,  E_RD,    M_MR);
    run_vec("lw.r1", 6'h23, 0, 0, ST_MR,  E_RD,    M_MR);
    run_vec("lw.r2", 6'h23, 0, 1, ST_MR,  E_RD,    M_MR);
    run_vec("lw.wb", 6'h23, 0, 1, ST_MWB, E_WB,    M_MWB);
    chk("lw.ir_pulses", 32'(n_ir), 32'd1);
    chk("lw.pc_pulses", 32'(n_pc), 32'd1);

    // beq taken, then not taken: 3 cycles each
    run_vec("beq1.f", 6'h04, 1, 1, ST_F,  E_FRDY, M_F);
    run_vec("beq1.d", 6'h04, 1, 1, ST_D,  E_NONE, M_D);
    run_vec("beq1.b", 6'h04, 1, 1, ST_BR, E_PC,   M_BR);
    run_vec("beq0.f", 6'h04, 0, 1, ST_F,  E_FRDY, M_F);
    run_vec("beq0.d", 6'h04, 0, 1, ST_D,  E_NONE, M_D);
    run_vec("beq0.b", 6'h04, 0, 1, ST_BR, E_NONE, M_BR);

    // sw: 4 cycles, no reg_write anywhere (covered by the enable vector)
    run_vec("sw.f",  6'h2B, 0, 1, ST_F,  E_FRDY, M_F);
    run_vec("sw.d",  6'h2B, 0, 1, ST_D,  E_NONE, M_D);
    run_vec("sw.ma", 6'h2B, 0, 1, ST_MA, E_NONE, M_MA);
    run_vec("sw.w",  6'h2B, 0, 1, ST_MW, E_WR,   M_MW);

    // j: 3 cycles
    run_vec("j.f", 6'h02, 0, 1, ST_F, E_FRDY, M_F);
    run_vec("j.d", 6'h02, 0, 1, ST_D, E_NONE, M_D);
    run_vec("j.j", 6'h02, 0, 1, ST_J, E_PC,   M_J);

    // addi: 4 cycles
    run_vec("addi.f",  6'h08, 0, 1, ST_F,   E_FRDY, M_F);
    run_vec("addi.d",  6'h08, 0, 1, ST_D,   E_NONE, M_D);
    run_vec("addi.ex", 6'h08, 0, 1, ST_IX,  E_NONE, M_IX);
    run_vec("addi.wb", 6'h08, 0, 1, ST_IWB, E_WB,   M_IWB);

    // sw stalled in MEM_WR, then reset mid-cycle
    run_vec("sw2.f",  6'h2B, 0, 1, ST_F,  E_FRDY, M_F);
    run_vec("sw2.d",  6'h2B, 0, 1, ST_D,  E_NONE, M_D);
    run_vec("sw2.ma", 6'h2B, 0, 1, ST_MA, E_NONE, M_MA);
    run_vec("sw2.w0", 6'h2B, 0, 0, ST_MW, E_WR,   M_MW);
    #1;
    chk("sw2.still_wr",  32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstwr.mem_write", 32'(mem_write), 32'd0);
    chk("rstwr.state",     32'(state),     32'd0);
    chk("rstwr.en",        32'(en_vec()),  32'(E_NONE));
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("rstwr.instr_cnt", instr_cnt, 32'd0);
    chk("rstwr.cycle_cnt", cycle_cnt, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // illegal opcode: HALT after DECODE, sticky for 20 cycles
    run_vec("ill.f", 6'h3F, 0, 1, ST_F, E_FRDY, M_F);
    run_vec("ill.d", 6'h3F, 0, 1, ST_D, E_NONE, M_D);
    for (int i = 0; i < 20; i++)
      run_vec($sformatf("halt%0d", i), 6'h3F, i[0], 1'(i[1]), ST_H, E_NONE, M_H);
    rst = 1'b1;
    #1;
    chk("unhalt.state",  32'(state),  32'd0);
    chk("unhalt.halted", 32'(halted), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // recovery: a normal R-type after the halt
    run_vec("r2.f",  6'h00, 0, 1, ST_F,   E_FRDY, M_F);
    run_vec("r2.d",  6'h00, 0, 1, ST_D,   E_NONE, M_D);
    run_vec("r2.ex", 6'h00, 0, 1, ST_RX,  E_NONE, M_RX);
    run_vec("r2.wb", 6'h00, 0, 1, ST_RWB, E_WB,   M_RWB);
    run_vec("r2.f2", 6'h00, 0, 0, ST_F,   E_FWAIT, M_F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the MIPS-subset datapath.
- Replaces the single-cycle decoder (UD), so one shared ALU and one unified memory serve fetch, address calculation and data access over several cycles.
- Sits beside the datapath. Consumes the opcode, the ALU zero flag and a memory-ready handshake. Drives every mux select, write enable and ALU op.
- Supports R-type, lw, sw, beq, j and addi. Any other opcode halts the core.

Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_LW, 6'h23, load word
- OP_SW, 6'h2B, store word
- OP_BEQ, 6'h04, branch if equal
- OP_J, 6'h02, jump
- OP_ADDI, 6'h08, add immediate

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26], taken from the instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable; already includes the branch condition
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  instruction register load
- reg_dst  out  1  write address select: 0 = rt, 1 = rd
- mem_to_reg  out  1  write data select: 0 = ALU result register, 1 = memory data register
- reg_write  out  1  register bank write enable
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- alu_op  out  3  000 = add, 001 = sub, 010 = decode funct
- pc_source  out  2  00 = ALU output, 01 = ALU result register (branch target), 10 = jump target
- halted  out  1  sticky illegal-opcode flag
- state  out  4  current state, for debug

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - rst is asynchronous, active-high. It forces state = FETCH(0) and halted = 0.
  - While rst is high, all enable outputs (pc_en, mem_read, mem_write, ir_write, reg_write) are forced to 0.
  - Reset asserted mid-instruction abandons that instruction; no partial write occurs after reset assertion.
- Output timing: outputs are combinational from state, op, zero and mem_ready. Every output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, HALT=12.
- States and transitions:
  - FETCH:
    - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_source=00.
    - ir_write and pc_en assert only when mem_ready=1.
    - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE:
    - Drives alu_src_a=0, alu_src_b=11, alu_op=000, which precomputes the branch target.
    - Next state: lw or sw -> MEM_ADDR; R-type -> R_EXEC; beq -> BRANCH; j -> JUMP; addi -> I_EXEC; any other opcode -> HALT.
  - MEM_ADDR:
    - Drives alu_src_a=1, alu_src_b=10, alu_op=000.
    - Next state: lw -> MEM_RD; sw -> MEM_WR.
  - MEM_RD:
    - Drives mem_read=1, iord=1.
    - Waits for mem_ready, then goes to MEM_WB.
  - MEM_WB:
    - Drives reg_write=1, reg_dst=0, mem_to_reg=1.
    - Next state is FETCH.
  - MEM_WR:
    - Drives mem_write=1, iord=1.
    - mem_write stays high until mem_ready=1, then next state is FETCH.
  - R_EXEC:
    - Drives alu_src_a=1, alu_src_b=00, alu_op=010.
    - Next state is R_WB.
  - R_WB:
    - Drives reg_write=1, reg_dst=1, mem_to_reg=0.
    - Next state is FETCH.
  - BRANCH:
    - Drives alu_src_a=1, alu_src_b=00, alu_op=001, pc_source=01, pc_en=zero.
    - Next state is FETCH.
  - JUMP:
    - Drives pc_source=10, pc_en=1.
    - Next state is FETCH.
  - I_EXEC:
    - Drives alu_src_a=1, alu_src_b=10, alu_op=000.
    - Next state is I_WB.
  - I_WB:
    - Drives reg_write=1, reg_dst=0, mem_to_reg=0.
    - Next state is FETCH.
  - HALT:
    - halted=1. All enables are 0.
    - Stays in HALT until rst.
- CPI with mem_ready tied to 1:
  - lw = 5
  - sw, R-type, addi = 4
  - beq, j = 3
- Each memory wait cycle adds 1.
- Any unused state encoding (13-15) goes to HALT on the next clock.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- When defined:
  - Adds output cycle_cnt[31:0], which increments every clock while not in HALT.
  - Adds output instr_cnt[31:0], which increments on every transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or I_WB.
  - Both counters clear on rst and wrap modulo 2^32.
- When not defined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then release with mem_ready=1 and op=6'h00 -> states 0,1,6,7,0. reg_write=1 only in state 7, with reg_dst=1. alu_op=010 in state 6.
- op=6'h23, mem_ready held 0 for 2 cycles in FETCH and in MEM_RD -> ir_write and pc_en pulse exactly once. The instruction takes 9 cycles total. The MEM_WB cycle has mem_to_reg=1.
- op=6'h04 with zero=1, then zero=0 -> pc_en=1 with pc_source=01 in BRANCH for the first case; pc_en=0 in BRANCH for the second. 3 cycles each.
- op=6'h2B -> mem_write=1 with iord=1 in state 5. reg_write is never asserted.
- op=6'h3F -> HALT(12) on the cycle after DECODE. halted=1 and all enables stay 0 for 20 cycles. Asserting rst returns state to 0 and halted to 0.
- Assert rst during MEM_WR with mem_ready=0 -> mem_write drops immediately, without waiting for a clock edge, and state=0. With PERF_EN defined, instr_cnt reads 0 after rst.
